// File: rtl/mult_div_ctrl.sv
// HI/LO multiply/divide controller: iterative radix-4 Booth multiplier and restoring divider.
// Optional feature macro MULT_DIV_UNSIGNED_EN enables MULTU (op 10) and DIVU (op 11).
module mult_div_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MULT_STEPS = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);
`ifdef MULT_DIV_UNSIGNED_EN
    localparam int LW = AW;
`else
    localparam int LW = WIDTH;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MULT    = 3'd1,
        S_DIV     = 3'd2,
        S_DIV_FIX = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CW-1:0]     cnt_r;
    logic [AW-1:0]     mcand_r;
    logic [AW-1:0]     mq_r;
    logic              prev_r;
    logic [AW-1:0]     acc_hi_r;
    logic [LW-1:0]     acc_lo_r;
    logic [WIDTH-1:0]  rem_r;
    logic [WIDTH-1:0]  quo_r;
    logic [WIDTH-1:0]  dvsr_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic              dz_r;
    logic [WIDTH-1:0]  hi_r;
    logic [WIDTH-1:0]  lo_r;

    logic              is_uns_s;
    logic              accept_s;
    logic              mult_last_s;
    logic              div_last_s;
    logic              dvsr_zero_s;
    logic              mul_commit_s;
    logic              div_commit_s;
    logic              busy_s;
    logic              done_s;
    logic [AW-1:0]     ext_a_s;
    logic [AW-1:0]     ext_b_s;
    logic [WIDTH-1:0]  abs_a_s;
    logic [WIDTH-1:0]  abs_b_s;
    logic [AW-1:0]     pp_s;
    logic [AW-1:0]     mul_sum_s;
    logic [AW-1:0]     mul_hi_nx_s;
    logic [LW-1:0]     mul_lo_nx_s;
    logic [WIDTH-1:0]  mul_hi_res_s;
    logic [WIDTH-1:0]  mul_lo_res_s;
    logic [WIDTH:0]    div_trial_s;
    logic [WIDTH-1:0]  rem_nx_s;
    logic [WIDTH-1:0]  quo_nx_s;
    logic [WIDTH-1:0]  q_fix_s;
    logic [WIDTH-1:0]  r_fix_s;

`ifdef MULT_DIV_UNSIGNED_EN
    logic              uns_r;
    assign is_uns_s    = op[1];
    assign mult_last_s = (cnt_r == (uns_r ? CW'(MULT_STEPS) : CW'(MULT_STEPS - 1)));
`else
    logic              unused_op_s;
    assign unused_op_s = op[1];
    assign is_uns_s    = 1'b0;
    assign mult_last_s = (cnt_r == CW'(MULT_STEPS - 1));
`endif

    assign accept_s     = start && !flush && ((state_r == S_IDLE) || (state_r == S_DONE));
    assign div_last_s   = (cnt_r == CW'(WIDTH - 1));
    assign dvsr_zero_s  = (dvsr_r == {WIDTH{1'b0}});
    assign mul_commit_s = (state_r == S_MULT) && mult_last_s && !flush;
    assign div_commit_s = (state_r == S_DIV_FIX) && !flush;

    assign ext_a_s = is_uns_s ? {2'b00, a} : {{2{a[WIDTH-1]}}, a};
    assign ext_b_s = is_uns_s ? {2'b00, b} : {{2{b[WIDTH-1]}}, b};
    assign abs_a_s = (!is_uns_s && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    assign abs_b_s = (!is_uns_s && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

    // Booth digit recoding from the two low multiplier bits and the previously consumed bit
    always_comb begin
        pp_s = {AW{1'b0}};
        case ({mq_r[1:0], prev_r})
            3'b001, 3'b010: pp_s = mcand_r;
            3'b011:         pp_s = {mcand_r[AW-2:0], 1'b0};
            3'b100:         pp_s = {AW{1'b0}} - {mcand_r[AW-2:0], 1'b0};
            3'b101, 3'b110: pp_s = {AW{1'b0}} - mcand_r;
            default:        pp_s = {AW{1'b0}};
        endcase
    end

    assign mul_sum_s   = acc_hi_r + pp_s;
    assign mul_hi_nx_s = {{2{mul_sum_s[AW-1]}}, mul_sum_s[AW-1:2]};
    assign mul_lo_nx_s = {mul_sum_s[1:0], acc_lo_r[LW-1:2]};

    // Product alignment: the unsigned run shifts two extra bits into the low half
    always_comb begin
        mul_hi_res_s = mul_hi_nx_s[WIDTH-1:0];
        mul_lo_res_s = mul_lo_nx_s[LW-1:LW-WIDTH];
`ifdef MULT_DIV_UNSIGNED_EN
        if (uns_r) begin
            mul_hi_res_s = {mul_hi_nx_s[WIDTH-3:0], mul_lo_nx_s[AW-1:WIDTH]};
            mul_lo_res_s = mul_lo_nx_s[WIDTH-1:0];
        end else begin
            mul_hi_res_s = mul_hi_nx_s[WIDTH-1:0];
            mul_lo_res_s = mul_lo_nx_s[AW-1:2];
        end
`endif
    end

    assign div_trial_s = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvsr_r};
    assign rem_nx_s    = div_trial_s[WIDTH] ? {rem_r[WIDTH-2:0], quo_r[WIDTH-1]} : div_trial_s[WIDTH-1:0];
    assign quo_nx_s    = {quo_r[WIDTH-2:0], ~div_trial_s[WIDTH]};
    assign q_fix_s     = neg_q_r ? ({WIDTH{1'b0}} - quo_r) : quo_r;
    assign r_fix_s     = neg_r_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:    state_s = accept_s ? (op[0] ? S_DIV : S_MULT) : S_IDLE;
            S_MULT:    state_s = mult_last_s ? S_DONE : S_MULT;
            S_DIV:     state_s = dvsr_zero_s ? S_DONE : (div_last_s ? S_DIV_FIX : S_DIV);
            S_DIV_FIX: state_s = S_DONE;
            S_DONE:    state_s = accept_s ? (op[0] ? S_DIV : S_MULT) : S_IDLE;
            default:   state_s = S_IDLE;
        endcase
        if (flush) begin
            state_s = S_IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // Output decode from the registered state
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            S_MULT, S_DIV, S_DIV_FIX: busy_s = 1'b1;
            S_DONE:                   done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Operand capture and per-cycle multiply/divide iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CW{1'b0}};
            mcand_r  <= {AW{1'b0}};
            mq_r     <= {AW{1'b0}};
            prev_r   <= 1'b0;
            acc_hi_r <= {AW{1'b0}};
            acc_lo_r <= {LW{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            dvsr_r   <= {WIDTH{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dz_r     <= 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
            uns_r    <= 1'b0;
`endif
        end else if (accept_s) begin
            cnt_r    <= {CW{1'b0}};
            mcand_r  <= ext_a_s;
            mq_r     <= ext_b_s;
            prev_r   <= 1'b0;
            acc_hi_r <= {AW{1'b0}};
            acc_lo_r <= {LW{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= abs_a_s;
            dvsr_r   <= abs_b_s;
            neg_q_r  <= !is_uns_s && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r  <= !is_uns_s && a[WIDTH-1];
            dz_r     <= 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
            uns_r    <= is_uns_s;
`endif
        end else begin
            case (state_r)
                S_MULT: begin
                    acc_hi_r <= mul_hi_nx_s;
                    acc_lo_r <= mul_lo_nx_s;
                    mq_r     <= {{2{mq_r[AW-1]}}, mq_r[AW-1:2]};
                    prev_r   <= mq_r[1];
                    cnt_r    <= cnt_r + 1'b1;
                end
                S_DIV: begin
                    dz_r  <= dvsr_zero_s;
                    rem_r <= rem_nx_s;
                    quo_r <= quo_nx_s;
                    cnt_r <= cnt_r + 1'b1;
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Architectural HI/LO: result commit on entry to DONE, MTHI/MTLO only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (mul_commit_s) begin
            hi_r <= mul_hi_res_s;
            lo_r <= mul_lo_res_s;
        end else if (div_commit_s) begin
            hi_r <= r_fix_s;
            lo_r <= q_fix_s;
        end else if (!busy_s) begin
            if (hi_we) begin
                hi_r <= wdata;
            end
            if (lo_we) begin
                lo_r <= wdata;
            end
        end
    end

    assign hi       = hi_r;
    assign lo       = lo_r;
    assign busy     = busy_s;
    assign done     = done_s;
    assign div_zero = done_s && dz_r;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed self-checking bench for mult_div_ctrl (default build, plus MULT_DIV_UNSIGNED_EN cases when defined).
module tb_mult_div_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int tests = 0;
    int fails = 0;

    mult_div_ctrl #(.WIDTH(32), .MULT_STEPS(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Launch in the current cycle T; expect busy for T+1..T+lat-1 and the commit in cycle T+lat.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] ia,
                          input logic [31:0] ib, input int lat, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edz);
        op = o; a = ia; b = ib; start = 1'b1;
        tick();
        start = 1'b0; a = 32'h0BAD_F00D; b = 32'h1234_5678;
        for (int k = 1; k < lat; k++) begin
            check1($sformatf("%s.busy@%0d", tag, k), busy, 1'b1);
            check1($sformatf("%s.done@%0d", tag, k), done, 1'b0);
            tick();
        end
        check1({tag, ".done"}, done, 1'b1);
        check1({tag, ".busy_off"}, busy, 1'b0);
        check1({tag, ".div_zero"}, div_zero, edz);
        check({tag, ".hi"}, hi, ehi);
        check({tag, ".lo"}, lo, elo);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        #1;
        check("rst.hi", hi, 32'h0);
        check("rst.lo", lo, 32'h0);
        check1("rst.busy", busy, 1'b0);
        check1("rst.done", done, 1'b0);
        check1("rst.div_zero", div_zero, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        run_op("mult_3xm5", 2'b00, 32'h0000_0003, 32'hFFFF_FFFB, 17, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        tick();
        check1("idle_after_done.done", done, 1'b0);
        check1("idle_after_done.busy", busy, 1'b0);

        run_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 17, 32'h4000_0000, 32'h0000_0000, 1'b0);
        // launched from the DONE cycle above: back-to-back accept
        run_op("mult_max_x2", 2'b00, 32'h7FFF_FFFF, 32'h0000_0002, 17, 32'h0000_0000, 32'hFFFF_FFFE, 1'b0);
        run_op("div_m7_2", 2'b01, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("div_100_7", 2'b01, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
        run_op("div_7_m2", 2'b01, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD, 1'b0);
        tick();

        hi_we = 1'b1; wdata = 32'h0000_0011;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_0022;
        tick();
        lo_we = 1'b0;
        check("mthi", hi, 32'h0000_0011);
        check("mtlo", lo, 32'h0000_0022);

        run_op("div_zero", 2'b01, 32'h0000_1234, 32'h0000_0000, 2, 32'h0000_0011, 32'h0000_0022, 1'b1);
        tick();
        check1("div_zero.clear", div_zero, 1'b0);

        // Flush mid-multiply with a simultaneous start; MTHI/MTLO ignored while busy
        op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 8; k++) begin
            if (k == 3) begin
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            check1($sformatf("flush.busy@%0d", k), busy, 1'b1);
            tick();
            hi_we = 1'b0; lo_we = 1'b0;
        end
        check("busy_write.hi", hi, 32'h0000_0011);
        check("busy_write.lo", lo, 32'h0000_0022);
        flush = 1'b1; start = 1'b1;
        tick();
        flush = 1'b0; start = 1'b0;
        check1("flush.busy", busy, 1'b0);
        check1("flush.done", done, 1'b0);
        check("flush.hi", hi, 32'h0000_0011);
        check("flush.lo", lo, 32'h0000_0022);
        for (int k = 0; k < 20; k++) begin
            check1($sformatf("flush.no_done@%0d", k), done, 1'b0);
            tick();
        end
        check("flush.hi_late", hi, 32'h0000_0011);

        // Asynchronous reset in the middle of a divide
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.hi", hi, 32'h0);
        check("midrst.lo", lo, 32'h0);
        check1("midrst.busy", busy, 1'b0);
        check1("midrst.done", done, 1'b0);
        check1("midrst.div_zero", div_zero, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef MULT_DIV_UNSIGNED_EN
        run_op("multu_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("divu_max_2", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 34, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
`else
        run_op("op10_as_mult", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17, 32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op("op11_as_div", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
`endif
        tick();
        check1("final.idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
